// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle ARM core.
// Decodes the latched instruction (IR[31:12]), tracks the NZCV condition
// flags, gates each instruction's writes by its condition and steps the
// datapath through fetch / decode / execute / writeback.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Instr[19:0]       IR[31:12]: cond, op, funct, Rd
//   ALUFlags[3:0]     {N,Z,C,V} produced by the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite       datapath write strobes
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
//                     datapath mux selects and ALU operation
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read registers, evaluate condition into CondEx
// MEMADR   | compute load/store address (base +/- offset)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to Rd
// MEMWRITE | write store data to memory
// EXECR    | data-processing op with register operand
// EXECI    | data-processing op with immediate operand
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <= PC+8 + offset
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       u_bit;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign i_bit     = Instr[13];
    assign cmd       = Instr[12:9];
    assign s_bit     = Instr[8];     // also L for memory ops
    assign u_bit     = Instr[11];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) & ~s_bit, (op == 2'b10)};

    // Data-processing decode. CMP without S has no architectural effect
    // here, so it is treated as undefined.
    logic       dp_ok, dp_cmp, dp_arith;
    logic [1:0] dp_alu;

    always_comb begin
        dp_ok  = 1'b1;
        dp_cmp = 1'b0;
        dp_alu = 2'b00;
        case (cmd)
            4'b0100: dp_alu = 2'b00;
            4'b0010: dp_alu = 2'b01;
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            4'b1010: begin
                dp_alu = 2'b01;
                dp_cmp = 1'b1;
                dp_ok  = s_bit;
            end
            default: dp_ok = 1'b0;
        endcase
    end

    // Only ADD/SUB/CMP produce meaningful carry and overflow.
    assign dp_arith = ~dp_alu[1];

    logic flag_n, flag_z, flag_c, flag_v, cond_pass;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = ~flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = ~flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = ~flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = ~flag_v;
            4'h8: cond_pass = flag_c & ~flag_z;
            4'h9: cond_pass = ~flag_c | flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
            4'hD: cond_pass = flag_z | (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        condex_d   = condex_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        ALUControl = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                PCWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'd1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
                condex_d  = cond_pass;
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    2'b00:   state_d = dp_ok ? (i_bit ? S_EXECI : S_EXECR) : S_FETCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'd1;
                ALUControl = u_bit ? 2'b00 : 2'b01;
                state_d    = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'd1;
                RegWrite  = condex_q;
                PCWrite   = condex_q & (rd == 4'hF);
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
                state_d  = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'd1 : 2'd0;
                ALUControl = dp_alu;
                if (condex_q && s_bit) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (dp_arith) flags_d[1:0] = ALUFlags[1:0];
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = condex_q & ~dp_cmp;
                PCWrite  = condex_q & ~dp_cmp & (rd == 4'hF);
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                PCWrite   = condex_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed instruction table, mid-instruction
// reset sequences and random instructions, all checked cycle by cycle
// against an instruction-level reference model.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, memw, regw, irw, adr;
        logic [1:0] rs, srca, srcb, res, imm, alu;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  af;
        int          cycles;
        logic        reg_any;
        logic        pc_late;
        logic        mem_any;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] mflags;
    ctl_t exp_q[$];
    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ctl_t dut_ctl();
        ctl_t r;
        r.pcw = PCWrite;   r.memw = MemWrite; r.regw = RegWrite;
        r.irw = IRWrite;   r.adr = AdrSrc;    r.rs = RegSrc;
        r.srca = ALUSrcA;  r.srcb = ALUSrcB;  r.res = ResultSrc;
        r.imm = ImmSrc;    r.alu = ALUControl;
        return r;
    endfunction

    // ARM condition table: even codes test a predicate, odd codes invert it.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        if (cond == 4'hE) return 1'b1;
        return cond[0] ? !r : r;
    endfunction

    function automatic ctl_t base_ctl(input logic [31:0] ir);
        ctl_t b;
        b = '0;
        b.rs  = {ir[27:26] == 2'b01 && !ir[20], ir[27:26] == 2'b10};
        b.imm = ir[27:26];
        return b;
    endfunction

    function automatic ctl_t fetch_ctl(input logic [31:0] ir);
        ctl_t b;
        b = base_ctl(ir);
        b.pcw = 1'b1; b.irw = 1'b1; b.srca = 2'd1; b.srcb = 2'd2; b.res = 2'd2;
        return b;
    endfunction

    // Reference: expected controls for each cycle of one instruction,
    // and the architectural flag update it causes.
    task automatic model_instr(input logic [31:0] ir, input logic [3:0] af);
        logic [1:0] op;
        logic [3:0] cmd, rd;
        logic       pass, ok, cmp, arith;
        logic [1:0] alu;
        ctl_t       b, s;
        op  = ir[27:26];
        cmd = ir[24:21];
        rd  = ir[15:12];
        pass = cond_ok(ir[31:28], mflags);
        b = base_ctl(ir);
        exp_q.delete();
        exp_q.push_back(fetch_ctl(ir));
        s = b; s.srca = 2'd1; s.srcb = 2'd2; s.res = 2'd2;
        exp_q.push_back(s);
        ok = 1'b1; cmp = 1'b0; alu = 2'd0;
        arith = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd10);
        case (cmd)
            4'd4:  alu = 2'd0;
            4'd2:  alu = 2'd1;
            4'd0:  alu = 2'd2;
            4'd12: alu = 2'd3;
            4'd10: begin alu = 2'd1; cmp = 1'b1; ok = ir[20]; end
            default: ok = 1'b0;
        endcase
        if (op == 2'b01) begin
            s = b; s.srcb = 2'd1; s.alu = ir[23] ? 2'd0 : 2'd1;
            exp_q.push_back(s);
            if (ir[20]) begin
                s = b; s.adr = 1'b1; exp_q.push_back(s);
                s = b; s.res = 2'd1; s.regw = pass; s.pcw = pass && rd == 4'hF;
                exp_q.push_back(s);
            end else begin
                s = b; s.adr = 1'b1; s.memw = pass; exp_q.push_back(s);
            end
        end else if (op == 2'b10) begin
            s = b; s.srcb = 2'd1; s.res = 2'd2; s.pcw = pass;
            exp_q.push_back(s);
        end else if (op == 2'b00 && ok) begin
            s = b; s.srcb = ir[25] ? 2'd1 : 2'd0; s.alu = alu;
            exp_q.push_back(s);
            s = b; s.regw = pass && !cmp; s.pcw = pass && !cmp && rd == 4'hF;
            exp_q.push_back(s);
            if (pass && ir[20]) begin
                mflags[3:2] = af[3:2];
                if (arith) mflags[1:0] = af[1:0];
            end
        end
    endtask

    // Called in the low phase of a FETCH cycle; returns in the low phase of
    // the next FETCH cycle (or after the cycle bound expires).
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] af, input string tag,
                             output int cyc, output logic reg_any, output logic pc_late,
                             output logic mem_any);
        Instr = ir[31:12];
        ALUFlags = af;
        model_instr(ir, af);
        cyc = 0; reg_any = 1'b0; pc_late = 1'b0; mem_any = 1'b0;
        for (int c = 0; c < 9; c++) begin
            ctl_t a;
            #1;
            a = dut_ctl();
            if (c > 0 && a.irw) break;
            if (c < exp_q.size())
                check($sformatf("%s c%0d", tag, c), 32'(a), 32'(exp_q[c]));
            reg_any = reg_any | a.regw;
            mem_any = mem_any | a.memw;
            if (c > 0) pc_late = pc_late | a.pcw;
            cyc = c + 1;
            @(negedge clk);
        end
    endtask

    task automatic mid_reset(input logic [31:0] ir, input int ncyc, input string tag);
        ctl_t f;
        Instr = ir[31:12];
        ALUFlags = 4'hF;
        model_instr(ir, 4'hF);
        repeat (ncyc) @(negedge clk);
        #1 check({tag, " pre"}, 32'(dut_ctl()), 32'(exp_q[ncyc]));
        #1 reset = 1'b1;
        f = fetch_ctl(ir);
        #1 check({tag, " rst"}, 32'(dut_ctl()), 32'(f));
        @(posedge clk);
        #1 check({tag, " hold"}, 32'(dut_ctl()), 32'(f));
        @(negedge clk);
        reset = 1'b0;
        mflags = 4'h0;
    endtask

    function automatic logic [31:0] rnd_ir();
        logic [31:0] ir;
        logic [3:0]  cmds[5];
        int          k;
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};
        ir = $urandom();
        k = $urandom_range(0, 9);
        if (k < 2)      ir[27:26] = 2'b01;
        else if (k < 4) ir[27:26] = 2'b10;
        else if (k < 8) begin
            ir[27:26] = 2'b00;
            ir[24:21] = cmds[$urandom_range(0, 4)];
        end else if (k == 8) ir[27:26] = 2'b11;
        else ir[27:26] = 2'b00;
        if (ir[27:26] == 2'b00 && ir[24:21] == 4'd10) ir[20] = 1'b1;
        if ($urandom_range(0, 3) == 0) ir[15:12] = 4'hF;
        if ($urandom_range(0, 2) == 0) ir[31:28] = 4'hE;
        return ir;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic ra, pl, ma;
        tbl = '{
            '{32'hE2802005, 4'hF, 4, 1'b1, 1'b0, 1'b0},  // ADD R2,R0,#5
            '{32'hE5901004, 4'h0, 5, 1'b1, 1'b0, 1'b0},  // LDR R1,[R0,#4]
            '{32'hE5801004, 4'h0, 4, 1'b0, 1'b0, 1'b1},  // STR
            '{32'hE2533001, 4'h4, 4, 1'b1, 1'b0, 1'b0},  // SUBS -> Z
            '{32'h0A000002, 4'h0, 3, 1'b0, 1'b1, 1'b0},  // BEQ taken
            '{32'h1A000002, 4'h0, 3, 1'b0, 1'b0, 1'b0},  // BNE not taken
            '{32'hE3530000, 4'h2, 4, 1'b0, 1'b0, 1'b0},  // CMP -> C only
            '{32'hEC000000, 4'h0, 2, 1'b0, 1'b0, 1'b0},  // op 11 undefined
            '{32'h2A000000, 4'h0, 3, 1'b0, 1'b1, 1'b0},  // BCS taken
            '{32'h0A000000, 4'h0, 3, 1'b0, 1'b0, 1'b0},  // BEQ not taken
            '{32'hE280F004, 4'h0, 4, 1'b1, 1'b1, 1'b0},  // ADD PC
            '{32'hE590F000, 4'h0, 5, 1'b1, 1'b1, 1'b0},  // LDR PC
            '{32'hF2802005, 4'h0, 4, 1'b0, 1'b0, 1'b0},  // cond never
            '{32'hE2123000, 4'hF, 4, 1'b1, 1'b0, 1'b0},  // ANDS -> NZ, CV kept
            '{32'h4A000000, 4'h0, 3, 1'b0, 1'b1, 1'b0},  // BMI taken
            '{32'h6A000000, 4'h0, 3, 1'b0, 1'b0, 1'b0},  // BVS not taken
            '{32'h9A000000, 4'h0, 3, 1'b0, 1'b1, 1'b0},  // BLS taken
            '{32'hCA000000, 4'h0, 3, 1'b0, 1'b0, 1'b0},  // BGT not taken
            '{32'h15801004, 4'h0, 4, 1'b0, 1'b0, 1'b0},  // STRNE skipped
            '{32'hE0201002, 4'h0, 2, 1'b0, 1'b0, 1'b0},  // EOR unsupported
            '{32'hE1823001, 4'h0, 4, 1'b1, 1'b0, 1'b0}   // ORR register
        };
        reset = 1'b1;
        Instr = '0;
        ALUFlags = '0;
        mflags = 4'h0;
        #2 check("reset outputs", 32'(dut_ctl()), 32'(fetch_ctl(32'h0)));
        @(negedge clk);
        @(negedge clk);
        check("reset held", 32'(dut_ctl()), 32'(fetch_ctl(32'h0)));
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            run_instr(tbl[i].ir, tbl[i].af, $sformatf("tbl%0d", i), cyc, ra, pl, ma);
            check($sformatf("tbl%0d cycles", i), 32'(cyc), 32'(tbl[i].cycles));
            check($sformatf("tbl%0d regwrite", i), 32'(ra), 32'(tbl[i].reg_any));
            check($sformatf("tbl%0d late pcwrite", i), 32'(pl), 32'(tbl[i].pc_late));
            check($sformatf("tbl%0d memwrite", i), 32'(ma), 32'(tbl[i].mem_any));
        end

        // Set Z, reset in MEMREAD: flags must clear so BEQ falls through.
        run_instr(32'hE2533001, 4'h4, "subs_a", cyc, ra, pl, ma);
        mid_reset(32'hE5901004, 3, "rst_memread");
        run_instr(32'h0A000002, 4'h0, "beq_after_rst", cyc, ra, pl, ma);
        check("beq_after_rst taken", 32'(pl), 32'(0));
        check("beq_after_rst cycles", 32'(cyc), 32'(3));
        run_instr(32'hE2533001, 4'h4, "subs_b", cyc, ra, pl, ma);
        mid_reset(32'hE5801004, 3, "rst_memwrite");
        mid_reset(32'hE5901004, 4, "rst_memwb");
        run_instr(32'h1A000002, 4'h0, "bne_after_rst", cyc, ra, pl, ma);
        check("bne_after_rst taken", 32'(pl), 32'(1));

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ir;
            int          nexp;
            ir = rnd_ir();
            run_instr(ir, 4'($urandom()), $sformatf("rnd%0d %h", i, ir), cyc, ra, pl, ma);
            nexp = exp_q.size();
            check($sformatf("rnd%0d %h cycles", i, ir), 32'(cyc), 32'(nexp));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle ARM core; it sits at the controller end of the datapath's control/status interface.
- Consumes the latched instruction and ALU flags from the datapath. Drives every datapath enable and mux select, plus the memory write strobe.
- Contains the main FSM, an instruction decoder, condition-flag registers and conditional-execution gating.

Parameters:
- none

Ports:
- clk  input  1  system clock; rising edge
- reset  input  1  asynchronous, active-high reset
- Instr  input  20  IR bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  address select: 0=PC, 1=ALUOut
- RegSrc  output  2  [0]=1 reads R15 on RA1; [1]=1 reads Rd on RA2
- ALUSrcA  output  2  0=A, 1=PC, 2=ALUOut
- ALUSrcB  output  2  0=WriteData, 1=ExtImm, 2=constant 4
- ResultSrc  output  2  0=ALUOut, 1=Data, 2=ALUResult
- ImmSrc  output  2  00=8-bit data-processing immediate, 01=12-bit memory offset, 10=24-bit branch
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR

Behaviour:
- Reset (async): state <= FETCH; flags NZCV <= 0000; CondEx latch <= 0. While reset is held, outputs show FETCH values.
- Decode, by op:
  - op 00: data processing. I=Instr[25], cmd=Instr[24:21], S=Instr[20]. Supported cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write, S required).
  - op 01: memory. L=Instr[20] (1=LDR). U=Instr[23] selects offset ADD (1) or SUB (0).
  - op 10: branch.
  - op 11 or an unsupported cmd: undefined.
- Combinational outputs: ImmSrc = op. RegSrc[0] = (op==10). RegSrc[1] = (op==01 & L==0).
- Condition check: cond field against the stored flags, standard ARM table for 0000..1110 (1110 = always). cond 1111 never executes.
- CondEx latch: loaded at the end of DECODE, held until the next DECODE. It gates all later writes of that instruction.
- State outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=2, ALUControl=00, ResultSrc=2, PCWrite=1 unconditionally. Next state DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2 (supplies R15=PC+8). Next state by op: 01 -> MEMADR; 00 with I=0 -> EXECR; 00 with I=1 -> EXECI; 10 -> BRANCH; undefined -> FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=1, ALUControl=00 if U else 01. Next state MEMREAD if L, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=0. Next state MEMWB.
  - MEMWB: ResultSrc=1, RegWrite=CondEx, PCWrite=CondEx&(Rd==15). Next state FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=CondEx. Next state FETCH.
  - EXECR / EXECI: ALUSrcA=0, ALUSrcB=0 (EXECR) or 1 (EXECI), ALUControl from cmd. On the clock edge leaving this state, flags are written only if CondEx & S: NZ <= ALUFlags[3:2], and CV <= ALUFlags[1:0] only for ADD/SUB/CMP. Next state ALUWB.
  - ALUWB: ResultSrc=0, RegWrite=CondEx & !CMP, PCWrite=CondEx & !CMP & (Rd==15). Next state FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=1, ALUControl=00, ResultSrc=2, PCWrite=CondEx. Next state FETCH.
- Latency per instruction: B 3 cycles, DP/CMP 4, STR 4, LDR 5, undefined 2.
- Instruction bits must only be interpreted after DECODE; IR is stable from then on.
- Reset mid-instruction: all write strobes drop immediately and the FSM restarts at FETCH.

Test Plan:
- ADD immediate: reset, Instr=0xE2802005 (ADD R2,R0,#5) -> states FETCH,DECODE,EXECI,ALUWB. EXECI shows ALUSrcB=01, ALUControl=00. ALUWB shows RegWrite=1, PCWrite=0. PCWrite=1 only in FETCH.
- LDR: Instr=0xE5901004 (LDR R1,[R0,#4]) -> 5 cycles. MEMADR: ImmSrc=01, ALUControl=00. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1.
- STR: Instr=0xE5801004 -> RegSrc=10 throughout. MemWrite=1 only in cycle 4 (MEMWRITE). RegWrite never asserted.
- SUBS then branches:
  - Instr=0xE2533001 (SUBS R3,R3,#1) with ALUFlags=0100 in EXECI -> Z stored.
  - Then 0x0A000002 (BEQ) -> PCWrite=1 in BRANCH, RegSrc=01.
  - Then 0x1A000002 (BNE) -> PCWrite=0 in BRANCH.
- CMP and undefined op:
  - 0xE3530000 (CMP R3,#0) -> ALUWB has RegWrite=0, flags updated.
  - 0xEC000000 (op 11) -> DECODE goes straight to FETCH, no writes.
- Async reset mid-MEMREAD: assert reset asynchronously -> same cycle state=FETCH, MemWrite/RegWrite=0, flags=0000. After release the next edge goes to DECODE.
